// File: rtl/enc_dec_pkg.sv
// ============================================================================
// Module      : enc_dec_pkg
// Description : Shared register map, operation/width codes and launcher FSM
//               states for the encoder/decoder register controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package enc_dec_pkg;

  localparam int unsigned AMBA_ADDR_WIDTH_DEF = 20;
  localparam int unsigned AMBA_WORD_DEF       = 32;

  localparam logic [3:0] REG_CTRL_OFS           = 4'h0;
  localparam logic [3:0] REG_DATA_IN_OFS        = 4'h4;
  localparam logic [3:0] REG_CODEWORD_WIDTH_OFS = 4'h8;
  localparam logic [3:0] REG_NOISE_OFS          = 4'hC;

  typedef enum logic [1:0] {
    REG_CTRL           = 2'b00,
    REG_DATA_IN        = 2'b01,
    REG_CODEWORD_WIDTH = 2'b10,
    REG_NOISE          = 2'b11
  } reg_sel_e;

  typedef enum logic [1:0] {
    OP_ENCODE       = 2'b00,
    OP_DECODE       = 2'b01,
    OP_FULL_CHANNEL = 2'b10,
    OP_ILLEGAL      = 2'b11
  } op_e;

  // Width code bit 1 set means 32-bit regardless of bit 0.
  localparam logic [1:0] WIDTH_8B  = 2'b00;
  localparam logic [1:0] WIDTH_16B = 2'b01;
  localparam logic [1:0] WIDTH_32B = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_e;

  function automatic reg_sel_e offset_to_sel(input logic [3:0] ofs);
    return reg_sel_e'(ofs[3:2]);
  endfunction

  function automatic logic is_launch_op(input logic [1:0] op);
    return (op != OP_ILLEGAL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_reg_ctrl_if.sv
// ============================================================================
// Module      : apb_reg_ctrl_if
// Description : APB slave bus bundle for apb_reg_ctrl. PSLVERR exists only
//               when APB_SLVERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_reg_ctrl_if #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
);

  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic [AMBA_WORD-1:0]       PRDATA;
`ifdef APB_SLVERR_EN
  logic                       PSLVERR;
`endif

  modport master (
    output PADDR,
    output PSEL,
    output PENABLE,
    output PWRITE,
    output PWDATA,
`ifdef APB_SLVERR_EN
    input  PSLVERR,
`endif
    input  PRDATA
  );

  modport slave (
    input  PADDR,
    input  PSEL,
    input  PENABLE,
    input  PWRITE,
    input  PWDATA,
`ifdef APB_SLVERR_EN
    output PSLVERR,
`endif
    output PRDATA
  );

endinterface

`default_nettype wire

// File: rtl/apb_access_decode.sv
// ============================================================================
// Module      : apb_access_decode
// Description : Turns an APB access phase into per-register write strobes, a
//               read enable/select and (with APB_SLVERR_EN) an address error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_access_decode
  import enc_dec_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 20
) (
  input  wire logic                       i_psel,
  input  wire logic                       i_penable,
  input  wire logic                       i_pwrite,
  input  wire logic [AMBA_ADDR_WIDTH-1:0] i_paddr,
  output logic      [3:0]                 o_wr_strb,
  output logic                            o_rd_en,
  output reg_sel_e                        o_rd_sel,
`ifdef APB_SLVERR_EN
  output logic                            o_access,
  output logic                            o_addr_err,
`endif
  output logic                            o_unused_out
);

  logic     w_access;
  logic     w_addr_ok;
  reg_sel_e w_sel;

  assign w_access = i_psel & i_penable;
  assign w_sel    = offset_to_sel(i_paddr[3:0]);

`ifdef APB_SLVERR_EN
  // Any upper address bit set makes the access a no-op and an error.
  assign w_addr_ok    = (i_paddr[AMBA_ADDR_WIDTH-1:4] == '0);
  assign o_access     = w_access;
  assign o_addr_err   = w_access & ~w_addr_ok;
  assign o_unused_out = ^i_paddr[1:0];
`else
  // Upper address bits are don't-care, so the map aliases every 16 bytes.
  assign w_addr_ok    = 1'b1;
  assign o_unused_out = ^{i_paddr[AMBA_ADDR_WIDTH-1:4], i_paddr[1:0]};
`endif

  always_comb begin
    o_wr_strb = 4'b0000;
    if (w_access && i_pwrite && w_addr_ok) begin
      o_wr_strb[w_sel] = 1'b1;
    end
  end

  assign o_rd_en  = w_access & ~i_pwrite & w_addr_ok;
  assign o_rd_sel = w_sel;

endmodule

`default_nettype wire

// File: rtl/apb_reg_ctrl.sv
// ============================================================================
// Module      : apb_reg_ctrl
// Description : APB register bank and launcher for the encoder/decoder core.
//               Optional PSLVERR reporting enabled by APB_SLVERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_reg_ctrl
  import enc_dec_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  apb_reg_ctrl_if.slave             apb,
  input  wire logic                 operation_done,
  output logic      [AMBA_WORD-1:0] ctrl,
  output logic      [AMBA_WORD-1:0] data_in,
  output logic      [AMBA_WORD-1:0] codeword_width,
  output logic      [AMBA_WORD-1:0] noise,
  output logic                      start,
  output logic                      busy
);

  logic [3:0]           w_wr_strb;
  logic                 w_rd_en;
  reg_sel_e             w_rd_sel;
  logic                 w_unused_dec;
  logic                 w_busy;
  logic                 w_launch;

  logic [AMBA_WORD-1:0] r_regs [4];
  logic [AMBA_WORD-1:0] r_prdata;
  fsm_state_e           r_state;
  logic                 r_start;

`ifdef APB_SLVERR_EN
  logic                 w_access;
  logic                 w_addr_err;
  logic                 w_err;
  logic                 r_pslverr;
`endif

  apb_access_decode #(
    .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH)
  ) u_decode (
    .i_psel       (apb.PSEL),
    .i_penable    (apb.PENABLE),
    .i_pwrite     (apb.PWRITE),
    .i_paddr      (apb.PADDR),
    .o_wr_strb    (w_wr_strb),
    .o_rd_en      (w_rd_en),
    .o_rd_sel     (w_rd_sel),
`ifdef APB_SLVERR_EN
    .o_access     (w_access),
    .o_addr_err   (w_addr_err),
`endif
    .o_unused_out (w_unused_dec)
  );

  assign w_busy   = (r_state == RUN);
  assign w_launch = w_wr_strb[REG_CTRL] & ~w_busy & is_launch_op(apb.PWDATA[1:0]);

  // Writes arriving while busy (including the operation_done cycle) are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= '0;
      end
    end else if (!w_busy) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_strb[i]) begin
          r_regs[i] <= apb.PWDATA;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prdata <= '0;
    end else if (w_rd_en) begin
      r_prdata <= r_regs[w_rd_sel];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_start <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_state <= RUN;
            r_start <= 1'b1;
          end
        end
        RUN: begin
          if (operation_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef APB_SLVERR_EN
  assign w_err = w_addr_err |
                 (w_access & apb.PWRITE &
                  (w_busy | ((offset_to_sel(apb.PADDR[3:0]) == REG_CTRL) &&
                             (apb.PWDATA[1:0] == OP_ILLEGAL))));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pslverr <= 1'b0;
    end else begin
      r_pslverr <= w_err;
    end
  end

  assign apb.PSLVERR = r_pslverr;
`endif

  assign apb.PRDATA     = r_prdata;
  assign ctrl           = r_regs[REG_CTRL];
  assign data_in        = r_regs[REG_DATA_IN];
  assign codeword_width = r_regs[REG_CODEWORD_WIDTH];
  assign noise          = r_regs[REG_NOISE];
  assign start          = r_start;
  assign busy           = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_apb_reg_ctrl.sv
// ============================================================================
// Module      : tb_apb_reg_ctrl
// Description : Directed self-checking bench for apb_reg_ctrl; PSLVERR checks
//               are included when APB_SLVERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        operation_done = 1'b0;
  logic [31:0] ctrl, data_in, codeword_width, noise;
  logic        start, busy;

  int          checks = 0;
  int          errors = 0;
  int          start_cnt = 0;
  logic [31:0] rd;

  apb_reg_ctrl_if #(.AMBA_ADDR_WIDTH(20), .AMBA_WORD(32)) apb ();

  apb_reg_ctrl #(
    .AMBA_ADDR_WIDTH (20),
    .AMBA_WORD       (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .apb            (apb),
    .operation_done (operation_done),
    .ctrl           (ctrl),
    .data_in        (data_in),
    .codeword_width (codeword_width),
    .noise          (noise),
    .start          (start),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start === 1'b1) start_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [19:0] addr, input logic [31:0] data, input logic done);
    @(negedge clk);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = addr; apb.PWDATA = data;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    operation_done = done;
    @(negedge clk);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    operation_done = 1'b0;
  endtask

  task automatic apb_read(input logic [19:0] addr, output logic [31:0] data);
    @(negedge clk);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = addr;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    @(negedge clk);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    data = apb.PRDATA;
  endtask

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ctrl", ctrl, 32'h0);
    check("rst_data_in", data_in, 32'h0);
    check("rst_cw", codeword_width, 32'h0);
    check("rst_noise", noise, 32'h0);
    check("rst_start", {31'h0, start}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_prdata", apb.PRDATA, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    apb_read(20'h0, rd); check("rd0_ctrl", rd, 32'h0);
    apb_read(20'h4, rd); check("rd0_data_in", rd, 32'h0);
    apb_read(20'h8, rd); check("rd0_cw", rd, 32'h0);
    apb_read(20'hC, rd); check("rd0_noise", rd, 32'h0);

    // Write / readback
    apb_write(20'h4, 32'h0000_00A5, 1'b0);
    check("wr_data_in_out", data_in, 32'h0000_00A5);
    apb_write(20'h8, 32'h0000_0001, 1'b0);
    check("wr_cw_out", codeword_width, 32'h0000_0001);
    apb_write(20'hC, 32'h0000_0003, 1'b0);
    check("wr_noise_out", noise, 32'h0000_0003);
    apb_read(20'h4, rd); check("rb_data_in", rd, 32'h0000_00A5);
    apb_read(20'h8, rd); check("rb_cw", rd, 32'h0000_0001);
    apb_read(20'hC, rd); check("rb_noise", rd, 32'h0000_0003);
    check("rb_no_start", start_cnt, 0);
    apb_read(20'h7, rd); check("rb_lowbits_ignored", rd, 32'h0000_00A5);
    @(negedge clk);
    @(negedge clk);
    check("prdata_hold", apb.PRDATA, 32'h0000_00A5);

    // Launch at edge N, busy lock, done at N+6
    apb_write(20'h0, 32'h0000_0002, 1'b0);
    check("launch_start_n1", {31'h0, start}, 32'h1);
    check("launch_busy_n1", {31'h0, busy}, 32'h1);
    check("launch_ctrl", ctrl, 32'h2);
    @(negedge clk);
    check("launch_start_n2", {31'h0, start}, 32'h0);
    check("launch_busy_n2", {31'h0, busy}, 32'h1);
    apb_write(20'h4, 32'hFFFF_FFFF, 1'b0);
    check("busy_wr_dropped", data_in, 32'h0000_00A5);
    check("busy_still", {31'h0, busy}, 32'h1);
`ifdef APB_SLVERR_EN
    check("busy_wr_slverr", {31'h0, apb.PSLVERR}, 32'h1);
`endif
    @(negedge clk);
`ifdef APB_SLVERR_EN
    check("busy_wr_slverr_clear", {31'h0, apb.PSLVERR}, 32'h0);
`endif
    operation_done = 1'b1;
    check("busy_before_done", {31'h0, busy}, 32'h1);
    @(negedge clk);
    operation_done = 1'b0;
    check("busy_cleared_at_done", {31'h0, busy}, 32'h0);
    check("single_start", start_cnt, 1);
    apb_read(20'h4, rd); check("busy_rb_data_in", rd, 32'h0000_00A5);

    // Write coinciding with operation_done is dropped, next one accepted
    apb_write(20'h0, 32'h0000_0001, 1'b0);
    check("launch2_busy", {31'h0, busy}, 32'h1);
    apb_write(20'h8, 32'h0000_0002, 1'b1);
    check("done_wr_busy_clear", {31'h0, busy}, 32'h0);
    check("done_wr_dropped", codeword_width, 32'h0000_0001);
    apb_write(20'h8, 32'h0000_0002, 1'b0);
    check("post_done_wr", codeword_width, 32'h0000_0002);
    check("launch2_count", start_cnt, 2);

    // Illegal op code is stored but never launches
    apb_write(20'h0, 32'h0000_0003, 1'b0);
    check("illegal_start", {31'h0, start}, 32'h0);
    check("illegal_busy", {31'h0, busy}, 32'h0);
`ifdef APB_SLVERR_EN
    check("illegal_slverr", {31'h0, apb.PSLVERR}, 32'h1);
`endif
    apb_read(20'h0, rd); check("illegal_rb", rd, 32'h0000_0003);
    check("illegal_no_start", start_cnt, 2);

    // Upper address bits: alias by default, no-op with error reporting
    apb_write(20'h14, 32'h0000_005A, 1'b0);
`ifdef APB_SLVERR_EN
    check("upper_addr_noop", data_in, 32'h0000_00A5);
    check("upper_addr_slverr", {31'h0, apb.PSLVERR}, 32'h1);
`else
    check("upper_addr_alias", data_in, 32'h0000_005A);
`endif

    // Reset mid-operation
    apb_write(20'h0, 32'h0000_0000, 1'b0);
    check("launch3_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_data_in", data_in, 32'h0);
    check("midrst_cw", codeword_width, 32'h0);
    check("midrst_noise", noise, 32'h0);
    check("midrst_prdata", apb.PRDATA, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    operation_done = 1'b1;
    @(negedge clk);
    operation_done = 1'b0;
    check("late_done_busy", {31'h0, busy}, 32'h0);
    check("late_done_start", {31'h0, start}, 32'h0);
    check("launch3_count", start_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_reg_ctrl.md
# apb_reg_ctrl

APB slave register bank and operation launcher sitting directly upstream of the encoder/decoder core. It holds the four programmable registers (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE) and issues a one-cycle start pulse when CTRL is written. It freezes the operands while the core is busy and releases them on `operation_done`.

## Interface
- `AMBA_ADDR_WIDTH`, 20, APB address width
- `AMBA_WORD`, 32, APB data and register width
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `PADDR` in AMBA_ADDR_WIDTH: byte address
- `PSEL` in 1: APB select
- `PENABLE` in 1: APB access phase
- `PWRITE` in 1: 1 = write, 0 = read
- `PWDATA` in AMBA_WORD: write data
- `PRDATA` out AMBA_WORD: read data, registered
- `operation_done` in 1: core completion pulse
- `ctrl` out AMBA_WORD: CTRL register
- `data_in` out AMBA_WORD: DATA_IN register
- `codeword_width` out AMBA_WORD: CODEWORD_WIDTH register
- `noise` out AMBA_WORD: NOISE register
- `start` out 1: one-cycle launch pulse to the core
- `busy` out 1: operation in flight, operands frozen
- `PSLVERR` out 1: only with `APB_SLVERR_EN`

## Operation
- **Access**
  - An access occurs on a cycle with `PSEL & PENABLE`. There are zero wait states, so every access completes in that cycle.
  - Decode uses `PADDR[3:2]`: 00 CTRL, 01 DATA_IN, 10 CODEWORD_WIDTH, 11 NOISE.
  - `PADDR[1:0]` is ignored. `PADDR[AMBA_ADDR_WIDTH-1:4]` is ignored, except as noted under Configuration.
- **Write**
  - The full word is stored on the access edge when `busy`=0.
  - When `busy`=1 the write is dropped and registers are unchanged.
- **Read**
  - Always permitted, including when busy.
  - `PRDATA` is loaded with the selected register on the access edge.
  - `PRDATA` holds its value otherwise.
- **Launch**
  - An accepted CTRL write with `PWDATA[1:0]` ∈ {00, 01, 10} sets `start`=1 for exactly the next cycle and sets `busy`=1.
  - `PWDATA[1:0]`=11 is stored but does not launch.
- **State machine**, FSM states IDLE / RUN:
  - IDLE → RUN on a launching CTRL write. `start` is asserted during the first RUN cycle.
  - RUN → IDLE on `operation_done`=1.
  - `operation_done` while in IDLE is ignored.
- **Simultaneous events**
  - `operation_done` together with any write in the same cycle: the write is evaluated against the current `busy`=1 and dropped. `busy` clears at that edge.
  - A read together with a write cannot occur (single APB port).
- **Reset**
  - Asynchronous, at any time, including mid-operation.
  - All registers, `PRDATA`, `start`, `busy` and `PSLVERR` go to 0. The FSM goes to IDLE.
  - An in-flight core operation is abandoned, and a later `operation_done` is ignored.

## Timing
- Write to register output: the value is visible the cycle after the access edge.
- CTRL access edge at cycle N: `start`=1 and `busy`=1 during cycle N+1. `start`=0 from N+2 onward.
- `operation_done` high at edge M: `busy`=0 from M. The next write is accepted at the first access after M.
- Read: `PRDATA` is valid in the cycle after the access edge and stable until the next read.
- No combinational path from APB inputs to any output.

## Configuration
- **`APB_SLVERR_EN` defined**
  - `PSLVERR` is asserted for one cycle, aligned with `PRDATA` timing, on any of these accesses:
    - a write while busy;
    - a CTRL write with `PWDATA[1:0]`=11;
    - `PADDR[AMBA_ADDR_WIDTH-1:4]` ≠ 0, which is then treated as a no-op for both read and write.
- **Undefined**
  - No `PSLVERR` port.
  - Upper address bits are ignored, so the register map aliases.
  - Illegal accesses are silently dropped as above.

## Structure
- Shared package `enc_dec_pkg` holds:
  - register offsets (CTRL 0x0, DATA_IN 0x4, CODEWORD_WIDTH 0x8, NOISE 0xC);
  - operation codes (ENCODE 00, DECODE 01, FULL_CHANNEL 10);
  - width codes (8b 00, 16b 01, 32b 1x);
  - the IDLE/RUN state enum.
- One sub-module, `apb_access_decode`, is natural. It produces the write-enable strobes, read select and error qualifier from `PSEL`, `PENABLE`, `PWRITE` and `PADDR`.

## Test plan
- **Reset values:** reset asserted → all outputs 0. Read 0x0/0x4/0x8/0xC after release → `PRDATA`=0 each.
- **Write/readback:**
  - Write DATA_IN=0x0000_00A5, CODEWORD_WIDTH=0x1, NOISE=0x0000_0003.
  - Read each back → `PRDATA` returns the identical values. `start` stays 0 throughout.
- **Launch:**
  - Write CTRL=0x2 at edge N → `start`=1 only in cycle N+1 and `busy`=1.
  - `operation_done` at N+6 → `busy`=0 from N+6.
- **Busy lock:**
  - While busy, write DATA_IN=0xFFFF_FFFF → readback still 0x0000_00A5, no second `start`. With `APB_SLVERR_EN`, `PSLVERR`=1 for one cycle.
  - A write in the same cycle as `operation_done` is dropped.
- **Illegal op:** write CTRL=0x3 → CTRL reads back 0x3, `start` never asserts, `busy` stays 0.
- **Reset mid-operation:** launch, assert `rst` at N+3 → `busy`=0 and registers 0 immediately. A later `operation_done` pulse leaves `busy`=0.
